// File: rtl/code_dec_pkg.sv
// Shared constants and the decoded-word type for the streaming one-hot decoder.
package code_dec_pkg;

  localparam int unsigned CODE_W_DEF = 2;
  localparam int unsigned BUF_DEPTH  = 2;

  typedef struct packed {
    logic [2**CODE_W_DEF-1:0] onehot;
    logic                     none_flag;
  } dec_word_t;

endpackage

// File: rtl/code_dec_buf2.sv
// Two-entry FIFO storage with 1-bit wrapping pointers and an occupancy count.
module code_dec_buf2 #(
  parameter int unsigned W_DATA = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [W_DATA-1:0] i_wdata,
  output logic [W_DATA-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty
);

  logic [W_DATA-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == 2'(DEPTH));
  assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/code_decoder.sv
// Streaming binary-to-one-hot decoder with a 2-entry output buffer.
// Optional encoder-contract check enabled by defining CODE_DEC_ERR_CHK_EN.
module code_decoder
  import code_dec_pkg::*;
#(
  parameter int unsigned W_CODE = CODE_W_DEF,
  parameter int unsigned DEPTH  = BUF_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W_CODE-1:0]    code,
  input  logic                 code_vld,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2**W_CODE-1:0] onehot,
  output logic                 none_flag,
  output logic                 err
);

  localparam int unsigned W_ONEHOT = 2**W_CODE;
  localparam int unsigned W_WORD   = W_ONEHOT + 1;

  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [W_ONEHOT-1:0] w_onehot;
  logic [W_WORD-1:0]   w_wdata;
  logic [W_WORD-1:0]   w_rdata;

  assign w_push   = in_valid & in_ready;
  assign w_pop    = out_valid & out_ready;
  // code is only consulted when the encoder marks it valid.
  assign w_onehot = code_vld ? (W_ONEHOT'(1) << code) : '0;
  assign w_wdata  = {w_onehot, ~code_vld};

  code_dec_buf2 #(
    .W_DATA (W_WORD),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign in_ready               = ~w_full;
  assign out_valid              = ~w_empty;
  assign {onehot, none_flag}    = w_rdata;

`ifdef CODE_DEC_ERR_CHK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_push && !code_vld && (code != '0)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_code_decoder.sv
// Randomized scoreboard bench for code_decoder with a queue-based reference model.
module tb_code_decoder;
  import code_dec_pkg::*;

  localparam int unsigned W  = CODE_W_DEF;
  localparam int unsigned OH = 2**W;
`ifdef CODE_DEC_ERR_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  code = '0;
  logic          code_vld = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OH-1:0] onehot;
  logic          none_flag;
  logic          err;

  int        n_tests = 0;
  int        n_fail  = 0;
  dec_word_t sb[$];
  bit        err_exp = 1'b0;

  always #5 clk = ~clk;

  code_decoder #(
    .W_CODE (W),
    .DEPTH  (BUF_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .code      (code),
    .code_vld  (code_vld),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .onehot    (onehot),
    .none_flag (none_flag),
    .err       (err)
  );

  function automatic dec_word_t ref_word(input int c, input bit v);
    dec_word_t   w;
    int unsigned p;
    p           = v ? (2 ** c) : 0;
    w.onehot    = p[OH-1:0];
    w.none_flag = !v;
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Producer side of the scoreboard: record every accepted code.
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      sb.push_back(ref_word(int'(code), code_vld));
      if (ERR_EN && !code_vld && (code != '0)) err_exp = 1'b1;
    end
  end

  // Monitor: occupancy-derived handshake checks and in-order word compare.
  always @(negedge clk) begin
    dec_word_t e;
    if (rst_n) begin
      check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      check("in_ready", 32'(in_ready), 32'(sb.size() < 2));
      check("err", 32'(err), 32'(err_exp));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_word", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          check("onehot", 32'(onehot), 32'(e.onehot));
          check("none_flag", 32'(none_flag), 32'(e.none_flag));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input int c, input bit v);
    in_valid = 1'b1;
    code     = W'(c);
    code_vld = v;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit accepted;
    bit acc;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_onehot", 32'(onehot), 32'(0));
    check("rst_none_flag", 32'(none_flag), 32'(0));
    check("rst_err", 32'(err), 32'(0));

    // Single push, one-cycle latency.
    tick();
    out_ready = 1'b1;
    push_one(3, 1'b1);
    @(negedge clk);
    check("t1_valid", 32'(out_valid), 32'(1));
    check("t1_onehot", 32'(onehot), 32'(4'b1000));
    tick();

    // Back-to-back pushes.
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      code     = W'(c);
      code_vld = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();

    // Fill under backpressure, then drain.
    out_ready = 1'b0;
    push_one(1, 1'b1);
    push_one(2, 1'b1);
    in_valid = 1'b1;
    code     = W'(3);
    code_vld = 1'b1;
    @(negedge clk);
    check("t3_full", 32'(in_ready), 32'(0));
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    #1 in_valid = 1'b0;
    check("t3_accept", 32'(accepted), 32'(1));
    repeat (4) tick();

    // No-line-active word.
    push_one(0, 1'b0);
    @(negedge clk);
    check("t4_onehot", 32'(onehot), 32'(0));
    check("t4_none", 32'(none_flag), 32'(1));
    check("t4_err", 32'(err), 32'(0));
    tick();

    // Contract violation: code!=0 with code_vld=0.
    push_one(2, 1'b0);
    @(negedge clk);
    check("t5_onehot", 32'(onehot), 32'(0));
    check("t5_none", 32'(none_flag), 32'(1));
    repeat (3) tick();
    check("t5_err_sticky", 32'(err), 32'(ERR_EN));

    // Randomized traffic with stable-while-stalled upstream.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      acc = in_valid && in_ready;
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        code     = W'($urandom);
        code_vld = ($urandom_range(0, 7) != 0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    check("rand_drained", 32'(sb.size()), 32'(0));

    // Reset while full.
    out_ready = 1'b0;
    push_one(1, 1'b1);
    push_one(2, 1'b1);
    @(negedge clk);
    check("t6_full", 32'(in_ready), 32'(0));
    #2 rst_n = 1'b0;
    sb.delete();
    err_exp = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'(0));
    check("t6_rst_ready", 32'(in_ready), 32'(1));
    check("t6_rst_err", 32'(err), 32'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) tick();
    check("t6_no_stale", 32'(out_valid), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
